// File: rtl/fetch_ctrl_pkg.sv
// Shared CPU-side definitions for the instruction fetch path.
// Widths, PC stride, fetch state encoding and the queue entry layout.
package fetch_ctrl_pkg;

  localparam int XLEN    = 32;
  localparam int INST_W  = 32;
  localparam int ENTRY_W = XLEN + INST_W;

  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_ctrl_fifo.sv
// Small synchronous FIFO holding captured {pc, inst} pairs for decode.
// Head is read straight from the storage flops, so it is registered.
module fetch_fifo
  import fetch_ctrl_pkg::*;
#(
  parameter int QDEPTH = 2,
  parameter int W      = ENTRY_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] wdata,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);

  logic [W-1:0]  mem_q [QDEPTH];
  logic [W-1:0]  mem_d [QDEPTH];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full  = (count_q == CW'(QDEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rptr_q];

  // A push into a full queue is only legal when the head leaves the same cycle.
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && !flush && (!full || do_pop);

  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wptr_q] = wdata;
        wptr_d        = wptr_q + PW'(1);
      end
      if (do_pop) begin
        rptr_d = rptr_q + PW'(1);
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q   <= '{default: '0};
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, captures ROM words into the
// fetch queue, and handles redirects, halt/resume and the retired count.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic [XLEN-1:0]   pc_out,
  input  logic [INST_W-1:0] inst_in,
  input  logic              redir_valid,
  input  logic [XLEN-1:0]   redir_pc,
  input  logic              halt_req,
  output logic              id_valid,
  output logic [INST_W-1:0] id_inst,
  output logic [XLEN-1:0]   id_pc,
  input  logic              id_ready,
  output logic              halted,
  output logic [XLEN-1:0]   fetch_cnt
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] fetch_cnt_q, fetch_cnt_d;
  logic            halted_q, halted_d;

  logic            q_full, q_empty;
  logic            pop_hs, q_pop, q_push;
  fetch_entry_t    q_head, q_wdata;

  assign pc_out    = pc_q;
  assign halted    = halted_q;
  assign fetch_cnt = fetch_cnt_q;
  assign id_valid  = !q_empty;
  assign id_pc     = q_head.pc;
  assign id_inst   = q_head.inst;

  // A redirect squashes the queue, so a handshake in that cycle is discarded.
  assign pop_hs  = id_valid && id_ready;
  assign q_pop   = pop_hs && !redir_valid;
  assign q_push  = (state_q == RUN) && !redir_valid && (!q_full || pop_hs);
  assign q_wdata = '{pc: pc_q, inst: inst_in};

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    fetch_cnt_d = fetch_cnt_q;
    if (redir_valid) begin
      state_d = RUN;
      pc_d    = redir_pc & ~XLEN'(3);
    end else begin
      if (q_pop) fetch_cnt_d = fetch_cnt_q + 32'd1;
      if (q_push) pc_d = pc_q + PC_STEP;
      case (state_q)
        BOOT:    state_d = RUN;
        RUN:     if (halt_req) state_d = HALT;
        HALT:    state_d = HALT;
        default: state_d = BOOT;
      endcase
    end
    halted_d = (state_d == HALT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= BOOT;
      pc_q        <= RESET_PC;
      fetch_cnt_q <= '0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      fetch_cnt_q <= fetch_cnt_d;
      halted_q    <= halted_d;
    end
  end

  fetch_fifo #(
    .QDEPTH (QDEPTH),
    .W      (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (q_push),
    .pop   (q_pop),
    .flush (redir_valid),
    .wdata (q_wdata),
    .full  (q_full),
    .empty (q_empty),
    .head  (q_head)
  );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: queue-based reference model with a negedge monitor,
// directed scenarios followed by randomized redirect/halt/ready traffic.
module tb_fetch_ctrl;

  localparam int QD = 2;
  localparam int M_BOOT = 0, M_RUN = 1, M_HALT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_out, inst_in, redir_pc, id_inst, id_pc, fetch_cnt;
  logic        redir_valid, halt_req, id_valid, id_ready, halted;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] mq[$];
  logic [31:0] mpc, mcnt;
  int          mstate;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return {a[11:2], 22'h15A5A5} ^ 32'h0F0F_1234;
  endfunction

  assign inst_in = rom_word(pc_out);

  fetch_ctrl #(.RESET_PC(32'h0), .QDEPTH(QD)) dut (
    .clk        (clk),
    .rst        (rst),
    .pc_out     (pc_out),
    .inst_in    (inst_in),
    .redir_valid(redir_valid),
    .redir_pc   (redir_pc),
    .halt_req   (halt_req),
    .id_valid   (id_valid),
    .id_inst    (id_inst),
    .id_pc      (id_pc),
    .id_ready   (id_ready),
    .halted     (halted),
    .fetch_cnt  (fetch_cnt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mpc    = 32'h0;
    mcnt   = 32'h0;
    mstate = M_BOOT;
  endtask

  // One clock of the fetch rules, applied to the inputs present at the edge.
  task automatic model_step();
    int sz;
    bit pop;
    if (redir_valid) begin
      mq.delete();
      mpc    = {redir_pc[31:2], 2'b00};
      mstate = M_RUN;
      return;
    end
    sz  = mq.size();
    pop = (sz > 0) && id_ready;
    if (pop) begin
      mq.delete(0);
      mcnt = mcnt + 32'd1;
    end
    if (mstate == M_RUN && (sz < QD || pop)) begin
      mq.push_back({mpc, rom_word(mpc)});
      mpc = mpc + 32'd4;
    end
    if (mstate == M_BOOT) mstate = M_RUN;
    else if (mstate == M_RUN && halt_req) mstate = M_HALT;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) model_step();
    #1;
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    redir_valid = 1'b0;
    redir_pc    = '0;
    halt_req    = 1'b0;
    id_ready    = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Monitor: compare DUT outputs with the model's queue head and state.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("mon_id_valid", 64'(id_valid), 64'(mq.size() != 0));
        if (mq.size() != 0) begin
          check("mon_id_pc", 64'(id_pc), 64'(mq[0][63:32]));
          check("mon_id_inst", 64'(id_inst), 64'(mq[0][31:0]));
        end
        check("mon_halted", 64'(halted), 64'(mstate == M_HALT));
        check("mon_fetch_cnt", 64'(fetch_cnt), 64'(mcnt));
        check("mon_pc_out", 64'(pc_out), 64'(mpc));
      end
    end
  end

  initial begin
    logic [31:0] c0;
    bit          found;

    do_reset();
    check("rst_id_valid", 64'(id_valid), 64'h0);
    check("rst_id_inst", 64'(id_inst), 64'h0);
    check("rst_id_pc", 64'(id_pc), 64'h0);
    check("rst_halted", 64'(halted), 64'h0);
    check("rst_fetch_cnt", 64'(fetch_cnt), 64'h0);
    check("rst_pc_out", 64'(pc_out), 64'h0);

    // Free run with decode always ready.
    id_ready = 1'b1;
    tick();
    check("boot_no_valid", 64'(id_valid), 64'h0);
    tick();
    check("first_valid", 64'(id_valid), 64'h1);
    for (int k = 0; k < 8; k++) begin
      check("free_id_pc", 64'(id_pc), 64'(32'(4 * k)));
      tick();
    end
    check("free_cnt8", 64'(fetch_cnt), 64'd8);

    // Stall decode: queue fills, pc stops.
    do_reset();
    repeat (6) tick();
    check("stall_pc", 64'(pc_out), 64'h8);
    check("stall_valid", 64'(id_valid), 64'h1);
    check("stall_head", 64'(id_pc), 64'h0);
    id_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check("drain_id_pc", 64'(id_pc), 64'(32'(4 * k)));
      tick();
    end
    // Full queue with simultaneous push and pop every cycle.
    for (int k = 0; k < 4; k++) begin
      c0 = fetch_cnt;
      tick();
      check("fullpop_cnt", 64'(fetch_cnt), 64'(c0 + 32'd1));
    end

    // Redirect while full and popping: flush, pop not counted, aligned target.
    c0          = fetch_cnt;
    redir_valid = 1'b1;
    redir_pc    = 32'h0000_0C06;
    tick();
    redir_valid = 1'b0;
    check("redir_flush", 64'(id_valid), 64'h0);
    check("redir_nocount", 64'(fetch_cnt), 64'(c0));
    check("redir_pc_out", 64'(pc_out), 64'h0C04);
    tick();
    check("redir_id_pc", 64'(id_pc), 64'h0C04);
    check("redir_id_inst", 64'(id_inst), 64'(rom_word(32'h0C04)));

    // Halt pulse at pc 0x10.
    do_reset();
    id_ready = 1'b1;
    found    = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (pc_out == 32'h10) found = 1'b1;
      else tick();
    end
    check("halt_reach_0x10", 64'(found), 64'h1);
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    check("halt_flag", 64'(halted), 64'h1);
    check("halt_pc_hold", 64'(pc_out), 64'h14);
    check("halt_last_cap", 64'(id_pc), 64'h10);
    repeat (3) tick();
    check("halt_pc_hold2", 64'(pc_out), 64'h14);
    redir_valid = 1'b1;
    redir_pc    = 32'h18;
    tick();
    redir_valid = 1'b0;
    check("resume_halted", 64'(halted), 64'h0);
    tick();
    check("resume_id_pc", 64'(id_pc), 64'h18);

    // PC wrap-around.
    redir_valid = 1'b1;
    redir_pc    = 32'hFFFF_FFFC;
    tick();
    redir_valid = 1'b0;
    tick();
    check("wrap_id_pc0", 64'(id_pc), 64'hFFFF_FFFC);
    tick();
    check("wrap_id_pc1", 64'(id_pc), 64'h0);

    // Asynchronous reset during a redirect.
    redir_valid = 1'b1;
    redir_pc    = 32'h0000_0400;
    #2 rst = 1'b1;
    model_reset();
    #1;
    check("arst_id_valid", 64'(id_valid), 64'h0);
    check("arst_pc_out", 64'(pc_out), 64'h0);
    check("arst_fetch_cnt", 64'(fetch_cnt), 64'h0);
    check("arst_id_pc", 64'(id_pc), 64'h0);
    check("arst_id_inst", 64'(id_inst), 64'h0);
    check("arst_halted", 64'(halted), 64'h0);
    redir_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
    tick();
    check("arst_restart", 64'(id_pc), 64'h0);
    check("arst_restart_v", 64'(id_valid), 64'h1);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      id_ready    = ($urandom_range(0, 3) != 0);
      redir_valid = ($urandom_range(0, 15) == 0);
      redir_pc    = $urandom;
      halt_req    = ($urandom_range(0, 11) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
